// File: rtl/adv_timer_lut_array.sv
// Array of N_CH lookup tables sharing one N_IN-bit index, with rise/fall event pulses.
// Latency: signal_o is 0 cycles from signal_i by default, and 1 cycle when LUT_OUT_REG_EN is defined.
// No backpressure. Config written while active is shadowed and committed on sync_i.
module adv_timer_lut_array #(
  parameter int N_IN = 4,
  parameter int N_CH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_update_i,
  input  logic [N_CH*(2**N_IN)-1:0]  cfg_lut_i,
  input  logic                       sync_i,
  input  logic [N_IN-1:0]            signal_i,
  output logic [N_CH-1:0]            signal_o,
  output logic [N_CH-1:0]            rise_o,
  output logic [N_CH-1:0]            fall_o,
  output logic                       pending_o
);

  localparam int LUT_W = 2**N_IN;
  localparam int CFG_W = N_CH*LUT_W;

  logic             r_active;
  logic             pending;
  logic [CFG_W-1:0] active_lut;
  logic [CFG_W-1:0] shadow_lut;
  logic [N_CH-1:0]  prev;
  logic [N_CH-1:0]  lut_val;
  logic [N_CH-1:0]  sig;

  // Enable tracking and config update. The active table only changes at activation, while
  // inactive, or at a commit, so it never changes part way through a timer period.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_active   <= 1'b0;
      pending    <= 1'b0;
      active_lut <= '0;
      shadow_lut <= '0;
    end else if (!r_active) begin
      if (cfg_en_i) begin
        r_active   <= 1'b1;
        active_lut <= cfg_lut_i;
        pending    <= 1'b0;
      end else if (cfg_update_i) begin
        active_lut <= cfg_lut_i;
      end
    end else begin
      if (!cfg_en_i) begin
        // The active table is kept. The shadow is dropped.
        r_active   <= 1'b0;
        pending    <= 1'b0;
        shadow_lut <= '0;
      end else if (cfg_update_i && sync_i) begin
        active_lut <= cfg_lut_i;
        pending    <= 1'b0;
      end else if (cfg_update_i) begin
        shadow_lut <= cfg_lut_i;
        pending    <= 1'b1;
      end else if (sync_i && pending) begin
        active_lut <= shadow_lut;
        pending    <= 1'b0;
      end
    end
  end

  // Per-channel table lookup at the shared index.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [LUT_W-1:0] tbl;
    assign tbl        = active_lut[c*LUT_W +: LUT_W];
    assign lut_val[c] = tbl[signal_i];
  end

`ifdef LUT_OUT_REG_EN
  logic [N_CH-1:0] out_q;

  // Registered output stage. It is cleared whenever the block is inactive.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q <= '0;
    end else begin
      out_q <= r_active ? lut_val : '0;
    end
  end

  assign sig = out_q & {N_CH{r_active}};
`else
  assign sig = r_active ? lut_val : '0;
`endif

  // Previous output value for edge detection. It stays at 0 while the block is inactive,
  // because sig is gated.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev <= '0;
    end else begin
      prev <= sig;
    end
  end

  assign signal_o  = sig;
  assign rise_o    = sig & ~prev;
  assign fall_o    = ~sig & prev;
  assign pending_o = pending;

endmodule

// File: tb/tb_adv_timer_lut_array.sv
// Directed scoreboard bench for adv_timer_lut_array (N_IN=4, N_CH=2).
// Expected vectors are pushed when the stimulus is driven and popped when the outputs are sampled.
// The bench handles both builds, with and without LUT_OUT_REG_EN.
module tb_adv_timer_lut_array;

`ifdef LUT_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic        cfg_update_i = 1'b0;
  logic [31:0] cfg_lut_i = '0;
  logic        sync_i = 1'b0;
  logic [3:0]  signal_i = '0;
  logic [1:0]  signal_o, rise_o, fall_o;
  logic        pending_o;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  adv_timer_lut_array #(.N_IN(4), .N_CH(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_update_i(cfg_update_i),
    .cfg_lut_i(cfg_lut_i), .sync_i(sync_i), .signal_i(signal_i),
    .signal_o(signal_o), .rise_o(rise_o), .fall_o(fall_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  // Each vector is {signal_o, rise_o, fall_o, pending_o}.
  function automatic logic [6:0] ov(input logic [1:0] s, input logic [1:0] r,
                                    input logic [1:0] f, input logic p);
    return {s, r, f, p};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got sig/rise/fall/pend=%b_%b_%b_%b, want %b_%b_%b_%b", tag,
                  got[6:5], got[4:3], got[2:1], got[0], exp[6:5], exp[4:3], exp[2:1], exp[0]);
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", ov(signal_o, rise_o, fall_o, pending_o), 7'bx);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, ov(signal_o, rise_o, fall_o, pending_o), e.v);
    end
  endtask

  // Drive the inputs for one cycle just after a rising edge, then sample them mid-cycle.
  // The expected vector covers the state from the previous edge combined with these inputs.
  task automatic cyc(input string tag, input logic en, input logic upd, input logic syn,
                     input logic [3:0] si, input logic [31:0] lut,
                     input logic [6:0] e_comb, input logic [6:0] e_reg);
    exp_t e;
    @(posedge clk_i);
    #2;
    cfg_en_i = en; cfg_update_i = upd; sync_i = syn; signal_i = si; cfg_lut_i = lut;
    e.tag = tag;
    e.v   = REG ? e_reg : e_comb;
    sb_q.push_back(e);
    #3;
    pop_and_check();
  endtask

  localparam logic [31:0] L_EN  = {16'h8000, 16'h0001};
  localparam logic [31:0] L_ONE = {16'hFFFF, 16'hFFFF};
  localparam logic [6:0]  Z     = 7'b0;

  initial begin
    exp_t e;
    #3;
    e.tag = "reset"; e.v = Z; sb_q.push_back(e);
    pop_and_check();
    @(posedge clk_i); #2 rstn_i = 1'b1;

    // While idle, every index must give zero outputs.
    for (int i = 0; i < 16; i++)
      cyc($sformatf("idle_%0d", i), 1'b0, 1'b0, 1'b0, i[3:0], L_EN, Z, Z);

    // Enable, then switch the index so one channel falls and the other rises.
    cyc("en_pre",  1, 0, 0, 4'd0,  L_EN, Z, Z);
    cyc("en_1",    1, 0, 0, 4'd0,  L_EN, ov(2'b01, 2'b01, 2'b00, 0), Z);
    cyc("en_2",    1, 0, 0, 4'd15, L_EN, ov(2'b10, 2'b10, 2'b01, 0), ov(2'b01, 2'b01, 2'b00, 0));
    cyc("en_3",    1, 0, 0, 4'd15, L_EN, ov(2'b10, 2'b00, 2'b00, 0), ov(2'b10, 2'b10, 2'b01, 0));
    cyc("en_4",    1, 0, 0, 4'd15, L_EN, ov(2'b10, 0, 0, 0), ov(2'b10, 0, 0, 0));

    // A shadowed update has no effect on the outputs until sync_i commits it.
    cyc("sh_upd",  1, 1, 0, 4'd15, L_ONE, ov(2'b10, 0, 0, 0), ov(2'b10, 0, 0, 0));
    cyc("sh_pend", 1, 0, 0, 4'd15, L_EN,  ov(2'b10, 0, 0, 1), ov(2'b10, 0, 0, 1));
    cyc("sh_sync", 1, 0, 1, 4'd15, L_EN,  ov(2'b10, 0, 0, 1), ov(2'b10, 0, 0, 1));
    cyc("sh_c1",   1, 0, 0, 4'd15, L_EN,  ov(2'b11, 2'b01, 0, 0), ov(2'b10, 0, 0, 0));
    cyc("sh_c2",   1, 0, 0, 4'd15, L_EN,  ov(2'b11, 0, 0, 0), ov(2'b11, 2'b01, 0, 0));
    cyc("sh_c3",   1, 0, 0, 4'd15, L_EN,  ov(2'b11, 0, 0, 0), ov(2'b11, 0, 0, 0));

    // When update and sync arrive in the same cycle, the table loads directly.
    cyc("col",     1, 1, 1, 4'd15, 32'h0, ov(2'b11, 0, 0, 0), ov(2'b11, 0, 0, 0));
    cyc("col_1",   1, 0, 0, 4'd15, L_EN,  ov(2'b00, 0, 2'b11, 0), ov(2'b11, 0, 0, 0));
    cyc("col_2",   1, 0, 0, 4'd15, L_EN,  Z, ov(2'b00, 0, 2'b11, 0));
    cyc("col_3",   1, 0, 0, 4'd15, L_EN,  Z, Z);

    // sync_i with nothing pending must not commit the stale shadow, which holds all ones.
    cyc("syn_np",  1, 0, 1, 4'd15, L_ONE, Z, Z);
    cyc("syn_np1", 1, 0, 0, 4'd15, L_ONE, Z, Z);
    cyc("syn_np2", 1, 0, 0, 4'd15, L_ONE, Z, Z);

    // Disabling while an update is pending drops the pending flag.
    cyc("dis_upd", 1, 1, 0, 4'd15, L_ONE, Z, Z);
    cyc("dis_pnd", 1, 0, 0, 4'd15, L_ONE, ov(0, 0, 0, 1), ov(0, 0, 0, 1));
    cyc("dis_off", 0, 0, 0, 4'd15, L_ONE, ov(0, 0, 0, 1), ov(0, 0, 0, 1));
    cyc("dis_1",   0, 0, 0, 4'd15, L_ONE, Z, Z);

    // Re-enable with an update pending, then assert reset in the middle of the cycle.
    cyc("re_en",   1, 0, 0, 4'd0, L_ONE, Z, Z);
    cyc("re_1",    1, 0, 0, 4'd0, L_ONE, ov(2'b11, 2'b11, 0, 0), Z);
    cyc("re_2",    1, 1, 0, 4'd0, L_ONE, ov(2'b11, 0, 0, 0), ov(2'b11, 2'b11, 0, 0));
    cyc("re_3",    1, 0, 0, 4'd0, L_ONE, ov(2'b11, 0, 0, 1), ov(2'b11, 0, 0, 1));
    #1 rstn_i = 1'b0;
    #1;
    e.tag = "arst_now"; e.v = Z; sb_q.push_back(e);
    pop_and_check();
    @(posedge clk_i); #2;
    e.tag = "arst_hold"; e.v = Z; sb_q.push_back(e);
    pop_and_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
